pfd_tdc_5bit: RTL and testbench

- Digital phase/frequency detector for the ADPLL loop. It sits at the feedback end of the DCO.
- Measures, in system-clock cycles, the time between a reference edge and a DCO output edge.
- Emits a sign/magnitude error word in the same ctrl_sign/ctrl[4:0] format that the loop filter and DCO consume, plus a valid strobe and a lock indicator.

---
 rtl/pfd_tdc_5bit.sv | 160 ++++++++++++++++
 tb/tb_pfd_tdc_5bit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pfd_tdc_5bit.sv
// pfd_tdc_5bit: digital phase/frequency detector for the ADPLL feedback path.
// Measures, in clk cycles, the interval between a reference edge and a DCO
// edge, and reports it as a sign/magnitude error word for the loop filter/DCO.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   enable     measurement enable (0 forces IDLE and clears lock state)
//   ref_in     reference clock, asynchronous to clk
//   dco_in     DCO output, asynchronous to clk
//   ctrl_sign  0 = DCO lags (speed up), 1 = DCO leads (slow down)
//   ctrl       error magnitude in clk cycles, saturated at 31
//   ctrl_valid one-cycle strobe after a measurement closes
//   lock       high once LOCK_CNT consecutive closes were within LOCK_TOL
module pfd_tdc_5bit #(
    parameter int CNT_W    = 8,
    parameter int TIMEOUT  = 200,
    parameter int LOCK_TOL = 2,
    parameter int LOCK_CNT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ref_in,
    input  logic       dco_in,
    output logic       ctrl_sign,
    output logic [4:0] ctrl,
    output logic       ctrl_valid,
    output logic       lock
);

    localparam int LCW = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MAG_SAT   = CNT_W'(31);

    typedef enum logic [1:0] {IDLE, REF_LEAD, DCO_LEAD} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [LCW-1:0]   lock_cnt, lock_cnt_new;

    logic [1:0] ref_sync, dco_sync;
    logic       ref_hist, dco_hist;
    logic       ref_rise, dco_rise;

    logic             close;
    logic [CNT_W-1:0] mag;
    logic             sign;
    logic [4:0]       ctrl_new;
    logic             in_tol;

    // Synchronisers and edge history keep running regardless of enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ref_sync <= '0;
            dco_sync <= '0;
            ref_hist <= 1'b0;
            dco_hist <= 1'b0;
        end else begin
            ref_sync <= {ref_sync[0], ref_in};
            dco_sync <= {dco_sync[0], dco_in};
            ref_hist <= ref_sync[1];
            dco_hist <= dco_sync[1];
        end
    end

    assign ref_rise = ref_sync[1] & ~ref_hist;
    assign dco_rise = dco_sync[1] & ~dco_hist;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        close      = 1'b0;
        mag        = '0;
        sign       = 1'b0;
        if (!enable) begin
            state_next = IDLE;
            cnt_next   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ref_rise && dco_rise) begin
                        close = 1'b1;
                    end else if (ref_rise) begin
                        state_next = REF_LEAD;
                        cnt_next   = CNT_W'(1);
                    end else if (dco_rise) begin
                        state_next = DCO_LEAD;
                        cnt_next   = CNT_W'(1);
                    end
                end
                REF_LEAD: begin
                    if (dco_rise) begin
                        close = 1'b1;
                        mag   = cnt;
                    end else if (ref_rise || cnt == TIMEOUT_C) begin
                        close = 1'b1;
                        mag   = MAG_SAT;
                    end else if (cnt < TIMEOUT_C) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                DCO_LEAD: begin
                    sign = 1'b1;
                    if (ref_rise) begin
                        close = 1'b1;
                        mag   = cnt;
                    end else if (dco_rise || cnt == TIMEOUT_C) begin
                        close = 1'b1;
                        mag   = MAG_SAT;
                    end else if (cnt < TIMEOUT_C) begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: state_next = IDLE;
            endcase
            // The closing edge is consumed: always return to IDLE.
            if (close) begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        end
    end

    assign ctrl_new = (mag > MAG_SAT) ? 5'd31 : mag[4:0];
    assign in_tol   = (ctrl_new <= 5'(LOCK_TOL));

    always_comb begin
        lock_cnt_new = '0;
        if (in_tol) begin
            lock_cnt_new = (lock_cnt == LCW'(LOCK_CNT)) ? lock_cnt : lock_cnt + LCW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lock_cnt   <= '0;
            lock       <= 1'b0;
            ctrl       <= '0;
            ctrl_sign  <= 1'b0;
            ctrl_valid <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            ctrl_valid <= close;
            if (!enable) begin
                lock_cnt <= '0;
                lock     <= 1'b0;
            end else if (close) begin
                ctrl      <= ctrl_new;
                ctrl_sign <= sign;
                lock_cnt  <= lock_cnt_new;
                lock      <= (lock_cnt_new == LCW'(LOCK_CNT));
            end
        end
    end

endmodule

// File: tb/tb_pfd_tdc_5bit.sv
// Directed self-checking bench for pfd_tdc_5bit.
module tb_pfd_tdc_5bit;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       ref_in;
    logic       dco_in;
    logic       ctrl_sign;
    logic [4:0] ctrl;
    logic       ctrl_valid;
    logic       lock;

    int n_cmp = 0;
    int n_bad = 0;

    // Strobe monitor: counts valid pulses and captures outputs during them.
    int         valid_cnt = 0;
    logic [4:0] last_ctrl = '0;
    logic       last_sign = 1'b0;
    logic       last_lock = 1'b0;

    pfd_tdc_5bit #(
        .CNT_W(8),
        .TIMEOUT(200),
        .LOCK_TOL(2),
        .LOCK_CNT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .ref_in(ref_in),
        .dco_in(dco_in),
        .ctrl_sign(ctrl_sign),
        .ctrl(ctrl),
        .ctrl_valid(ctrl_valid),
        .lock(lock)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ctrl_valid) begin
            valid_cnt <= valid_cnt + 1;
            last_ctrl <= ctrl;
            last_sign <= ctrl_sign;
            last_lock <= lock;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one edge pair: leader first, follower 'lag' cycles later.
    task automatic run_meas(input bit ref_first, input int lag);
        ref_in = 1'b0;
        dco_in = 1'b0;
        wait_cyc(4);
        if (lag == 0) begin
            ref_in = 1'b1;
            dco_in = 1'b1;
        end else begin
            if (ref_first) ref_in = 1'b1; else dco_in = 1'b1;
            wait_cyc(lag);
            if (ref_first) dco_in = 1'b1; else ref_in = 1'b1;
        end
        wait_cyc(7);
    endtask

    task automatic test_reset;
        reset  = 1'b0;
        enable = 1'b1;
        ref_in = 1'b0;
        dco_in = 1'b0;
        wait_cyc(3);
        n_cmp++;
        if ({ctrl, ctrl_sign, ctrl_valid, lock} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_outputs: got ctrl=%0d sign=%b valid=%b lock=%b, want all 0",
                     ctrl, ctrl_sign, ctrl_valid, lock);
        end
        reset = 1'b1;
        wait_cyc(3);
    endtask

    task automatic test_basic;
        int base;
        base = valid_cnt;
        run_meas(1'b1, 5);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd5 || last_sign !== 1'b0) begin
            n_bad++;
            $display("FAIL ref_lead_5: got pulses=%0d ctrl=%0d sign=%b, want 1/5/0",
                     valid_cnt - base, last_ctrl, last_sign);
        end
        base = valid_cnt;
        run_meas(1'b0, 12);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd12 || last_sign !== 1'b1) begin
            n_bad++;
            $display("FAIL dco_lead_12: got pulses=%0d ctrl=%0d sign=%b, want 1/12/1",
                     valid_cnt - base, last_ctrl, last_sign);
        end
        n_cmp++;
        if (ctrl !== 5'd12 || ctrl_sign !== 1'b1 || ctrl_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_after_strobe: got ctrl=%0d sign=%b valid=%b, want 12/1/0",
                     ctrl, ctrl_sign, ctrl_valid);
        end
        base = valid_cnt;
        run_meas(1'b1, 0);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd0 || last_sign !== 1'b0) begin
            n_bad++;
            $display("FAIL simultaneous: got pulses=%0d ctrl=%0d sign=%b, want 1/0/0",
                     valid_cnt - base, last_ctrl, last_sign);
        end
        // A following single-edge measurement proves the FSM returned to IDLE.
        base = valid_cnt;
        run_meas(1'b0, 3);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd3 || last_sign !== 1'b1) begin
            n_bad++;
            $display("FAIL after_simul: got pulses=%0d ctrl=%0d sign=%b, want 1/3/1",
                     valid_cnt - base, last_ctrl, last_sign);
        end
    endtask

    task automatic test_saturation;
        int base;
        base = valid_cnt;
        run_meas(1'b1, 40);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd31 || last_sign !== 1'b0) begin
            n_bad++;
            $display("FAIL lag_40: got pulses=%0d ctrl=%0d sign=%b, want 1/31/0",
                     valid_cnt - base, last_ctrl, last_sign);
        end
        ref_in = 1'b0;
        dco_in = 1'b0;
        wait_cyc(4);
        base = valid_cnt;
        ref_in = 1'b1;
        wait_cyc(10);
        ref_in = 1'b0;
        wait_cyc(10);
        ref_in = 1'b1;
        wait_cyc(7);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd31 || last_sign !== 1'b0) begin
            n_bad++;
            $display("FAIL second_ref: got pulses=%0d ctrl=%0d sign=%b, want 1/31/0",
                     valid_cnt - base, last_ctrl, last_sign);
        end
        ref_in = 1'b0;
        wait_cyc(4);
    endtask

    task automatic test_timeout;
        int base;
        base = valid_cnt;
        ref_in = 1'b1;
        wait_cyc(198);
        n_cmp++;
        if (valid_cnt - base !== 0) begin
            n_bad++;
            $display("FAIL timeout_early: got pulses=%0d, want 0", valid_cnt - base);
        end
        wait_cyc(12);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd31 || last_sign !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout: got pulses=%0d ctrl=%0d sign=%b, want 1/31/0",
                     valid_cnt - base, last_ctrl, last_sign);
        end
        base = valid_cnt;
        run_meas(1'b1, 3);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd3 || last_sign !== 1'b0) begin
            n_bad++;
            $display("FAIL after_timeout: got pulses=%0d ctrl=%0d sign=%b, want 1/3/0",
                     valid_cnt - base, last_ctrl, last_sign);
        end
    endtask

    task automatic test_lock;
        int lags[4] = '{1, 2, 0, 2};
        for (int i = 0; i < 4; i++) begin
            run_meas(1'b1, lags[i]);
            n_cmp++;
            if (last_ctrl !== 5'(lags[i]) || last_lock !== (i == 3)) begin
                n_bad++;
                $display("FAIL lock_seq%0d: got ctrl=%0d lock_at_valid=%b, want %0d/%b",
                         i, last_ctrl, last_lock, lags[i], (i == 3));
            end
        end
        run_meas(1'b1, 10);
        n_cmp++;
        if (last_ctrl !== 5'd10 || last_lock !== 1'b0 || lock !== 1'b0) begin
            n_bad++;
            $display("FAIL lock_lost: got ctrl=%0d lock_at_valid=%b lock=%b, want 10/0/0",
                     last_ctrl, last_lock, lock);
        end
    endtask

    task automatic test_reset_abort;
        int base;
        ref_in = 1'b0;
        dco_in = 1'b0;
        wait_cyc(4);
        base = valid_cnt;
        ref_in = 1'b1;
        wait_cyc(6);
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ctrl, ctrl_sign, ctrl_valid, lock} !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_abort: got ctrl=%0d sign=%b valid=%b lock=%b, want all 0",
                     ctrl, ctrl_sign, ctrl_valid, lock);
        end
        ref_in = 1'b0;
        wait_cyc(2);
        reset = 1'b1;
        wait_cyc(10);
        n_cmp++;
        if (valid_cnt - base !== 0) begin
            n_bad++;
            $display("FAIL reset_no_strobe: got pulses=%0d, want 0", valid_cnt - base);
        end
        base = valid_cnt;
        run_meas(1'b0, 4);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd4 || last_sign !== 1'b1) begin
            n_bad++;
            $display("FAIL after_reset: got pulses=%0d ctrl=%0d sign=%b, want 1/4/1",
                     valid_cnt - base, last_ctrl, last_sign);
        end
    endtask

    task automatic test_enable_abort;
        int base;
        for (int i = 0; i < 4; i++) run_meas(1'b1, 1);
        n_cmp++;
        if (lock !== 1'b1 || ctrl !== 5'd1) begin
            n_bad++;
            $display("FAIL pre_disable_lock: got lock=%b ctrl=%0d, want 1/1", lock, ctrl);
        end
        ref_in = 1'b0;
        dco_in = 1'b0;
        wait_cyc(4);
        base = valid_cnt;
        ref_in = 1'b1;
        wait_cyc(6);
        enable = 1'b0;
        wait_cyc(3);
        n_cmp++;
        if (lock !== 1'b0 || ctrl !== 5'd1 || ctrl_sign !== 1'b0 || ctrl_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL disable: got lock=%b ctrl=%0d sign=%b valid=%b, want 0/1/0/0",
                     lock, ctrl, ctrl_sign, ctrl_valid);
        end
        ref_in = 1'b0;
        wait_cyc(3);
        enable = 1'b1;
        wait_cyc(6);
        n_cmp++;
        if (valid_cnt - base !== 0) begin
            n_bad++;
            $display("FAIL disable_no_strobe: got pulses=%0d, want 0", valid_cnt - base);
        end
        // Lock counter must restart from zero after the disable.
        base = valid_cnt;
        run_meas(1'b1, 1);
        n_cmp++;
        if (valid_cnt - base !== 1 || last_ctrl !== 5'd1 || lock !== 1'b0) begin
            n_bad++;
            $display("FAIL after_disable: got pulses=%0d ctrl=%0d lock=%b, want 1/1/0",
                     valid_cnt - base, last_ctrl, lock);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_timeout();
        test_lock();
        test_reset_abort();
        test_enable_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
